// File: rtl/if_fetch_if.sv
// Instruction SRAM port bundle driven by the fetch stage.
// The fetch stage is the master; the SRAM model or wrapper is the slave.
interface if_fetch_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  modport master (
    output inst_sram_en,
    output inst_sram_wen,
    output inst_sram_addr,
    output inst_sram_wdata
  );

  modport slave (
    input inst_sram_en,
    input inst_sram_wen,
    input inst_sram_addr,
    input inst_sram_wdata
  );
endinterface

// File: rtl/if_fetch.sv
// Fetch stage: PC sequencing with branch redirect and stall handling.
// A branch seen while the PC is held is parked until the stall lifts.
module if_fetch (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    stall,
  input  logic [32:0]   br_bus,
  output logic [32:0]   if_to_id_bus,
  if_fetch_if.master    sram
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD_BR
  } state_t;

  localparam logic [31:0] RST_PC  = 32'hBFBF_FFFC;
  localparam logic [31:0] BOOT_PC = 32'hBFC0_0000;

  state_t      state, state_n;
  logic [31:0] pc_reg, pc_n;
  logic        ce_reg, ce_n;
  logic        pend_v, pend_v_n;
  logic [31:0] pend_addr, pend_addr_n;

  logic        br_e;
  logic [31:0] br_addr;
  logic        hold;
  logic [31:0] next_pc;

  assign br_e    = br_bus[32];
  assign br_addr = br_bus[31:0];
  assign hold    = stall[0];

  // Live branch wins over a parked one; wraps modulo 2^32.
  always_comb begin
    if (br_e)        next_pc = br_addr;
    else if (pend_v) next_pc = pend_addr;
    else             next_pc = pc_reg + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BOOT;
      pc_reg    <= RST_PC;
      ce_reg    <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'h0;
    end else begin
      state     <= state_n;
      pc_reg    <= pc_n;
      ce_reg    <= ce_n;
      pend_v    <= pend_v_n;
      pend_addr <= pend_addr_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc_reg;
    ce_n        = ce_reg;
    pend_v_n    = pend_v;
    pend_addr_n = pend_addr;
    unique case (state)
      BOOT: begin
        pc_n    = BOOT_PC;
        ce_n    = 1'b1;
        state_n = RUN;
      end
      RUN: begin
        if (!hold) begin
          pc_n     = next_pc;
          pend_v_n = 1'b0;
        end else if (br_e) begin
          pend_addr_n = br_addr;
          pend_v_n    = 1'b1;
          state_n     = HOLD_BR;
        end
      end
      HOLD_BR: begin
        if (hold) begin
          if (br_e) pend_addr_n = br_addr;
        end else begin
          pc_n     = next_pc;
          pend_v_n = 1'b0;
          state_n  = RUN;
        end
      end
      default: begin
        state_n = BOOT;
      end
    endcase
  end

  assign if_to_id_bus         = {ce_reg, pc_reg};
  assign sram.inst_sram_en    = ce_reg;
  assign sram.inst_sram_addr  = pc_reg;
  assign sram.inst_sram_wen   = 4'b0000;
  assign sram.inst_sram_wdata = 32'h0;

endmodule

// File: tb/tb_if_fetch.sv
// Randomized bench for if_fetch against a queue-based fetch model.
// Directed scenarios first, then random stall/branch/reset traffic.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;

  if_fetch_if sram ();

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_bus       (br_bus),
    .if_to_id_bus (if_to_id_bus),
    .sram         (sram.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // Model: current fetch pc, whether it is live, and at most one
  // branch target waiting for the stall to lift.
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_booted;
  logic [31:0] m_pend[$];

  task automatic chk(string tag, logic [32:0] got, logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'hBFBF_FFFC;
    m_ce     = 1'b0;
    m_booted = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_edge(logic [5:0] s, logic [32:0] b);
    if (!m_booted) begin
      m_pc     = 32'hBFC0_0000;
      m_ce     = 1'b1;
      m_booted = 1'b1;
    end else if (!s[0]) begin
      if (b[32])               m_pc = b[31:0];
      else if (m_pend.size()>0) m_pc = m_pend[0];
      else                     m_pc = m_pc + 32'd4;
      m_pend.delete();
    end else if (b[32]) begin
      m_pend.delete();
      m_pend.push_back(b[31:0]);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".bus"}, if_to_id_bus, {m_ce, m_pc});
    chk({tag, ".en"}, {32'h0, sram.inst_sram_en}, {32'h0, m_ce});
    chk({tag, ".addr"}, {1'b0, sram.inst_sram_addr}, {1'b0, m_pc});
    chk({tag, ".wen"}, {29'h0, sram.inst_sram_wen}, 33'h0);
    chk({tag, ".wdata"}, {1'b0, sram.inst_sram_wdata}, 33'h0);
  endtask

  task automatic step(logic [5:0] s, logic br_e, logic [31:0] ba);
    stall  = s;
    br_bus = {br_e, ba};
    @(posedge clk);
    model_edge(s, {br_e, ba});
    #1;
    chk_all("step");
    stall  = 6'h0;
    br_bus = 33'h0;
  endtask

  task automatic addr_is(string tag, logic [31:0] a);
    chk(tag, {1'b0, sram.inst_sram_addr}, {1'b0, a});
  endtask

  // Assert reset mid-cycle, check it acts before any edge, then release.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst.en", {32'h0, sram.inst_sram_en}, 33'h0);
    chk("rst.bus", if_to_id_bus, 33'h0_BFBF_FFFC);
    addr_is("rst.addr", 32'hBFBF_FFFC);
    @(posedge clk);
    #1;
    chk_all("rst.hold");
    rst = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    stall  = 6'h0;
    br_bus = 33'h0;
    model_reset();
    #3;
    chk_all("por");
    chk("por.bus", if_to_id_bus, 33'h0_BFBF_FFFC);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Boot ignores stall and branch.
    step(6'h01, 1'b1, 32'h1234_5678);
    addr_is("boot", 32'hBFC0_0000);
    step(6'h00, 1'b0, 32'h0);
    addr_is("seq1", 32'hBFC0_0004);
    step(6'h3E, 1'b0, 32'h0);
    addr_is("seq2", 32'hBFC0_0008);
    step(6'h00, 1'b0, 32'h0);
    step(6'h00, 1'b0, 32'h0);
    addr_is("at10", 32'hBFC0_0010);

    step(6'h00, 1'b1, 32'hBFC0_0100);
    addr_is("br", 32'hBFC0_0100);
    step(6'h00, 1'b0, 32'h0);
    addr_is("br+4", 32'hBFC0_0104);

    step(6'h00, 1'b1, 32'hBFC0_0020);
    step(6'h01, 1'b1, 32'hBFC0_0200);
    addr_is("st1", 32'hBFC0_0020);
    step(6'h01, 1'b0, 32'h0);
    addr_is("st2", 32'hBFC0_0020);
    step(6'h01, 1'b0, 32'h0);
    addr_is("st3", 32'hBFC0_0020);
    step(6'h00, 1'b0, 32'h0);
    addr_is("pend", 32'hBFC0_0200);

    // Live branch at stall release beats the parked target.
    step(6'h01, 1'b1, 32'hBFC0_0200);
    step(6'h00, 1'b1, 32'hBFC0_0300);
    addr_is("live", 32'hBFC0_0300);
    step(6'h01, 1'b0, 32'h0);
    step(6'h00, 1'b0, 32'h0);
    addr_is("pclr", 32'hBFC0_0304);

    // Latest branch during a stall overwrites the parked one.
    step(6'h01, 1'b1, 32'hBFC0_0400);
    step(6'h01, 1'b1, 32'hBFC0_0503);
    step(6'h00, 1'b0, 32'h0);
    addr_is("ovr", 32'hBFC0_0503);

    step(6'h00, 1'b1, 32'hFFFF_FFFC);
    step(6'h00, 1'b0, 32'h0);
    addr_is("wrap", 32'h0000_0000);

    step(6'h01, 1'b1, 32'h1234_5678);
    async_reset();
    step(6'h00, 1'b0, 32'h0);
    addr_is("rboot", 32'hBFC0_0000);
    step(6'h00, 1'b0, 32'h0);
    addr_is("rdrop", 32'hBFC0_0004);

    for (int i = 0; i < 400; i++) begin
      logic [5:0]  s;
      logic        be;
      logic [31:0] ba;
      s  = 6'($urandom);
      s[0] = ($urandom_range(0, 9) < 4);
      be = ($urandom_range(0, 3) == 0);
      ba = $urandom;
      if ($urandom_range(0, 99) == 0) async_reset();
      else step(s, be, ba);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
